if_stage: RTL

- Instruction fetch stage, directly upstream of the decode stage.
- Owns the architectural fetch PC and issues sequential word fetches to the instruction memory port over a valid/ready request channel with an in-order response channel.
- Buffers returned instructions with their PCs and presents {inst, pc} to decode with a valid/ready handshake.
- Handles redirects from branch/jump resolution, discarding any wrong-path fetches still in flight.

---
 rtl/if_stage.sv | 114 +++++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited word fetches and
// buffers returned instructions with their PCs for decode; redirects discard wrong-path work.
module if_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_inst,
  output logic [XLEN-1:0] id_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] buf_inst_q [DEPTH];
  logic [XLEN-1:0] buf_pc_q   [DEPTH];
  logic [XLEN-1:0] ifq_pc_q   [DEPTH];
  logic [PW-1:0]   buf_rd_q, buf_rd_d, buf_wr_q, buf_wr_d;
  logic [PW-1:0]   ifq_rd_q, ifq_rd_d, ifq_wr_q, ifq_wr_d;
  logic [CW-1:0]   buf_cnt_q, buf_cnt_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic            has_credit, req_fire, resp_take, resp_keep, id_fire;

  assign has_credit     = ({1'b0, inflight_q} + {1'b0, buf_cnt_q}) < (CW+1)'(DEPTH);
  assign imem_req_valid = !rst && !redirect_valid && has_credit;
  assign imem_req_addr  = pc_q;

  assign id_valid = (buf_cnt_q != '0) && !redirect_valid;
  assign id_inst  = (buf_cnt_q != '0) ? buf_inst_q[buf_rd_q] : '0;
  assign id_pc    = (buf_cnt_q != '0) ? buf_pc_q[buf_rd_q]   : '0;

  assign req_fire  = imem_req_valid && imem_req_ready;
  // A response with nothing outstanding is a protocol error and is simply ignored.
  assign resp_take = imem_resp_valid && (inflight_q != '0);
  assign resp_keep = resp_take && (drop_q == '0) && !redirect_valid;
  assign id_fire   = id_valid && id_ready;

  // NOTE: every signal gets a default first so always_comb can never infer a latch.
  always_comb begin
    pc_d       = pc_q;
    buf_rd_d   = buf_rd_q;
    buf_wr_d   = buf_wr_q;
    buf_cnt_d  = buf_cnt_q;
    drop_d     = drop_q;
    ifq_rd_d   = ifq_rd_q + PW'(resp_take);
    ifq_wr_d   = ifq_wr_q + PW'(req_fire);
    inflight_d = inflight_q + CW'(req_fire) - CW'(resp_take);
    if (redirect_valid) begin
      pc_d      = redirect_pc & ~XLEN'(3);
      buf_rd_d  = '0;
      buf_wr_d  = '0;
      buf_cnt_d = '0;
      // Everything still outstanding after this cycle was fetched down the old path.
      drop_d    = inflight_q - CW'(resp_take);
    end else begin
      if (req_fire) pc_d = pc_q + XLEN'(4);
      if (resp_take && (drop_q != '0)) drop_d = drop_q - CW'(1);
      buf_wr_d  = buf_wr_q + PW'(resp_keep);
      buf_rd_d  = buf_rd_q + PW'(id_fire);
      buf_cnt_d = buf_cnt_q + CW'(resp_keep) - CW'(id_fire);
    end
  end

  // NOTE: state registers use non-blocking assignments so each one samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      buf_rd_q   <= '0;
      buf_wr_q   <= '0;
      buf_cnt_q  <= '0;
      ifq_rd_q   <= '0;
      ifq_wr_q   <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      buf_rd_q   <= buf_rd_d;
      buf_wr_q   <= buf_wr_d;
      buf_cnt_q  <= buf_cnt_d;
      ifq_rd_q   <= ifq_rd_d;
      ifq_wr_q   <= ifq_wr_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  // NOTE: storage arrays carry no reset; the counts and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (req_fire) ifq_pc_q[ifq_wr_q] <= pc_q;
    if (resp_keep) begin
      buf_inst_q[buf_wr_q] <= imem_resp_data;
      buf_pc_q[buf_wr_q]   <= ifq_pc_q[ifq_rd_q];
    end
  end

`ifndef SYNTHESIS
  a_resp_has_request: assert property (@(posedge clk) disable iff (rst)
    !(imem_resp_valid && (inflight_q == '0)));
`endif

endmodule
